addsub_seq_ctrl: RTL and testbench

//  Sequencer that runs WIDTH-bit add/subtract operations through a single 4-bit
//  add/sub slice, one nibble per clock, LSB nibble first, with a registered carry chain.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_slice4.sv | 26 ++
 rtl/addsub_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_addsub_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer: slice width,
// controller state encoding and the operation-length helper.
package addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slice passes needed to cover an operand of the given width.
    function automatic int calc_nibbles(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/addsub_slice4.sv
// 4-bit ripple add/sub slice. b is inverted when sub=1; the caller supplies
// the +1 of the two's complement through cin on the first nibble.
// c3 is the carry into bit 3, exposed so the caller can form signed overflow.
module addsub_slice4
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                sub,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W-1:0] w_bx;
    logic [NIBBLE_W-1:0] w_low;

    assign w_bx  = b ^ {NIBBLE_W{sub}};
    // Lower three bits plus their carry out, which is the carry into bit 3.
    assign w_low = {1'b0, a[2:0]} + {1'b0, w_bx[2:0]} + {3'b000, cin};
    assign c3    = w_low[3];
    assign s     = {a[3] ^ w_bx[3] ^ c3, w_low[2:0]};
    assign cout  = (a[3] & w_bx[3]) | (c3 & (a[3] ^ w_bx[3]));

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial WIDTH-bit add/sub sequencer built around one 4-bit slice.
// Operands are captured on accept, processed LSB nibble first with a
// registered carry, and the result is held until the consumer takes it.
// Optional feature macro: ADDSUB_OVF_EN adds the signed-overflow output ovf.
module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = calc_nibbles(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_width_check
        $fatal(1, "addsub_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_sub;
    logic [WIDTH-1:0]    r_result;
    logic                r_cout;

    logic [NIBBLE_W-1:0] w_a_nibs [NIBBLES];
    logic [NIBBLE_W-1:0] w_b_nibs [NIBBLES];
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_cout;
    logic                w_last;

    for (genvar g = 0; g < NIBBLES; g++) begin : g_nib
        assign w_a_nibs[g] = r_a[g*NIBBLE_W +: NIBBLE_W];
        assign w_b_nibs[g] = r_b[g*NIBBLE_W +: NIBBLE_W];
    end

    assign w_a_nib = w_a_nibs[r_idx];
    assign w_b_nib = w_b_nibs[r_idx];
    assign w_last  = (r_idx == LAST_IDX);

`ifdef ADDSUB_OVF_EN
    logic w_c3;
    logic r_ovf;
`else
    logic w_unused_c3;
`endif

    addsub_slice4 u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .sub  (r_sub),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout),
`ifdef ADDSUB_OVF_EN
        .c3   (w_c3)
`else
        .c3   (w_unused_c3)
`endif
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, step through nibbles, wait for the consumer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, per-nibble result/carry update, final flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
`ifdef ADDSUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sub   <= sub;
                        r_carry <= sub;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_result[i*NIBBLE_W +: NIBBLE_W] <= w_s;
                        end
                    end
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_cout <= w_cout;
`ifdef ADDSUB_OVF_EN
                        r_ovf  <= w_c3 ^ w_cout;
`endif
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    // DONE holds everything for the consumer.
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign cout      = r_cout;
`ifdef ADDSUB_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl: directed corner vectors, backpressure,
// mid-operation reset and randomized operations against a plain-arithmetic model.
// Build with ADDSUB_OVF_EN defined to also check the ovf output.
module tb_addsub_seq_ctrl;

    localparam int W       = 8;
    localparam int NIBBLES = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] tb_a;
    logic [W-1:0] tb_b;
    logic         tb_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
`ifdef ADDSUB_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    addsub_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (tb_a),
        .b         (tb_b),
        .sub       (tb_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
`ifdef ADDSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: {ovf, cout, result} from ordinary integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        if (s) begin
            t = {1'b0, x} - {1'b0, y};
            c = (x >= y);
        end else begin
            t = {1'b0, x} + {1'b0, y};
            c = t[W];
        end
        r = t[W-1:0];
        if (s) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        else   v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        return {v, c, r};
    endfunction

    // Drive random junk that the controller must ignore outside IDLE.
    task automatic junk_inputs();
        in_valid = 1'($urandom_range(0, 1));
        tb_a     = W'($urandom);
        tb_b     = W'($urandom);
        tb_sub   = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input int hold);
        logic [W+1:0] exp;
        exp       = model(x, y, s);
        in_valid  = 1'b1;
        tb_a      = x;
        tb_b      = y;
        tb_sub    = s;
        out_ready = 1'b0;
        check_eq("idle_ready", 64'(in_ready), 64'd1);
        tick();
        check_eq("acc_ready", 64'(in_ready), 64'd0);
        check_eq("acc_valid", 64'(out_valid), 64'd0);
        for (int k = 1; k <= NIBBLES; k++) begin
            junk_inputs();
            tick();
            check_eq("lat_valid", 64'(out_valid), 64'(k == NIBBLES));
            check_eq("run_ready", 64'(in_ready), 64'd0);
        end
        check_eq("result", 64'(result), 64'(exp[W-1:0]));
        check_eq("cout", 64'(cout), 64'(exp[W]));
`ifdef ADDSUB_OVF_EN
        check_eq("ovf", 64'(ovf), 64'(exp[W+1]));
`endif
        for (int h = 0; h < hold; h++) begin
            junk_inputs();
            in_valid = 1'b1;
            tick();
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_ready", 64'(in_ready), 64'd0);
            check_eq("hold_result", 64'(result), 64'(exp[W-1:0]));
            check_eq("hold_cout", 64'(cout), 64'(exp[W]));
        end
        out_ready = 1'b1;
        junk_inputs();
        in_valid  = 1'b1;
        tick();
        check_eq("rel_ready", 64'(in_ready), 64'd1);
        check_eq("rel_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        tb_a      = '0;
        tb_b      = '0;
        tb_sub    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_ready", 64'(in_ready), 64'd1);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_cout", 64'(cout), 64'd0);
`ifdef ADDSUB_OVF_EN
        check_eq("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;
        tick();

        // Directed corners.
        run_op(W'(8'h5A), W'(8'h3C), 1'b0, 0);
        run_op(W'(8'h30), W'(8'h45), 1'b1, 1);
        run_op(W'(8'h45), W'(8'h30), 1'b1, 0);
        run_op({W{1'b1}}, W'(1), 1'b0, 2);
        run_op(W'(8'hA7), W'(0), 1'b1, 0);
        run_op(W'(8'h7F), W'(8'h01), 1'b0, 0);
        run_op(W'(8'h80), W'(8'h01), 1'b1, 0);
        run_op(W'(8'h10), W'(8'h10), 1'b0, 0);
        run_op(W'(8'h3C), W'(8'h3C), 1'b1, 0);
        run_op(W'(8'h11), W'(8'h22), 1'b0, 5);

        // Reset on the first RUN edge discards the operation.
        in_valid = 1'b1;
        tb_a     = W'(8'h12);
        tb_b     = W'(8'h34);
        tb_sub   = 1'b0;
        tick();
        check_eq("mid_acc_ready", 64'(in_ready), 64'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        check_eq("mid_rst_ready", 64'(in_ready), 64'd1);
        check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_result", 64'(result), 64'd0);
        check_eq("mid_rst_cout", 64'(cout), 64'd0);
`ifdef ADDSUB_OVF_EN
        check_eq("mid_rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;
        for (int k = 0; k < NIBBLES + 2; k++) begin
            tick();
            check_eq("mid_no_valid", 64'(out_valid), 64'd0);
            check_eq("mid_idle_ready", 64'(in_ready), 64'd1);
        end

        // Randomized operations with random backpressure.
        for (int n = 0; n < 200; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
